rgb_cycle_decoder: RTL and testbench
====================================

# rgb_cycle_decoder

Receive-side checker for the six-hue RGB LED colour cycle. It samples three active-low LED-style lines, synchronises and debounces them, and decodes the accepted colour. It also measures how long each colour holds and flags sequence and timing violations against the hue wheel R→Y→G→C→B→M→R. It sits on the board's input pins, so one board can verify another board's colour-cycle output, or a looped-back copy of its own.

## Interface
- STEP_CYCLES, 2000000, nominal dwell per hue in clk cycles (2,000,000 = 1/6 s at 12 MHz)
- TOL_CYCLES, 1000, allowed ± deviation of a measured dwell from STEP_CYCLES
- DEBOUNCE_CYCLES, 16, consecutive stable cycles required before a new colour is accepted (≥1)
- DW, $clog2(STEP_CYCLES+TOL_CYCLES+2), width of the dwell counter and output
- clk  in  1  system clock, 12 MHz
- rst  in  1  asynchronous, active-high reset
- rgb_r_n, rgb_g_n, rgb_b_n  in  1 each  asynchronous active-low colour lines (0 = channel on)
- color  out  3  accepted colour, active-high, {R,G,B}
- step_pulse  out  1  one-cycle strobe on every accepted colour change
- dwell  out  DW  cycles the previous colour was held, latched at each accepted change
- locked  out  1  high while in LOCKED state
- seq_err  out  1  sticky: an out-of-order hue transition occurred
- timing_err  out  1  sticky: a dwell was out of tolerance, or the cycle stalled

## Operation
- **Synchronisation.** Each line passes through a 2-flop synchroniser; the flops reset to 1 (channel off). The synchronised value is inverted to form `raw[2:0]` = {R,G,B}.
- **Debounce.**
  - A candidate register holds the last raw value. A stability counter clears whenever raw ≠ candidate; otherwise it increments.
  - When the counter reaches DEBOUNCE_CYCLES−1 and candidate ≠ color, `color` ← candidate and `step_pulse` is asserted.
  - Glitches shorter than DEBOUNCE_CYCLES are never accepted.
- **Hue set and successor function.**
  - Hues: 100, 110, 010, 011, 001, 101.
  - succ(): 100→110→010→011→001→101→100.
  - 000 (off) and 111 (white) are non-hues.
- **Dwell counter.**
  - Increments every cycle and saturates at all-ones.
  - On an accepted change: `dwell` ← counter+1 (cycles since the previous change), then the counter clears.
- **FSM (IDLE, SYNC, LOCKED).** Checks use the old and new colour at the accepted change.
  - IDLE: on a change to a hue → SYNC. No checks.
  - SYNC: on a change, if new = succ(old) → LOCKED. The first dwell is partial, so it is not timed. Otherwise set seq_err; next state is SYNC if new is a hue, else IDLE.
  - LOCKED, change with new = succ(old): stay in LOCKED. If dwell < STEP_CYCLES−TOL_CYCLES or > STEP_CYCLES+TOL_CYCLES, set timing_err.
  - LOCKED, change with new ≠ succ(old): set seq_err; next state is SYNC if new is a hue, else IDLE.
  - LOCKED, no change: when the counter reaches STEP_CYCLES+TOL_CYCLES+1, set timing_err and → SYNC (stall detected once).
- **Sticky errors.** seq_err and timing_err clear only on rst.

## Timing
- **Reset values.** color=000, step_pulse=0, dwell=0, locked=0, seq_err=0, timing_err=0. FSM=IDLE, synchronisers=1, candidate=000, stability and dwell counters=0.
- **Acceptance latency.** A pin change that is stable before rising edge k produces color/step_pulse after edge k+1+DEBOUNCE_CYCLES (2 sync + debounce). The latency is constant, so a source stepping every N cycles yields dwell = N exactly.
- **Error flag timing.** seq_err and timing_err rise in the same cycle as step_pulse for change-based checks. For a stall, they rise on the cycle after the counter reaches the threshold.
- **locked timing.** locked changes on the clock edge following the step_pulse cycle that triggers the transition.
- **Simultaneous events.** If an accepted change and the stall threshold occur in the same cycle, the change takes priority and only the change checks apply.
- **Multi-channel changes.** Multiple channels changing within the debounce window resolve to the final stable value as a single change.
- **Reset mid-operation.** Reset mid-operation returns every output to its reset value immediately, since reset is asynchronous. Operation restarts from IDLE on the first clk edge after rst deasserts.

## Test plan
Bench parameters: STEP_CYCLES=100, TOL_CYCLES=4, DEBOUNCE_CYCLES=4.

- **Clean cycle.** Drive a clean cycle starting at R, stepping every 100 cycles for 3 full revolutions → locked=1 after the 2nd change; every dwell after the first = 100; seq_err=0, timing_err=0; step_pulse count = 18.
- **Glitch rejection.** A 3-cycle glitch (G line low) during R → color stays 100, no step_pulse. A 4-cycle stable G with R off → color=010 after 6 edges.
- **Out-of-order hue.** While locked at G, step to M (101) → seq_err=1 with step_pulse; state SYNC, locked=0. Resume the correct sequence → locked=1 again; seq_err stays 1.
- **Dwell tolerance.** While locked, one step at 95 cycles → timing_err=1, dwell=95, locked stays 1. A step at 104 alone causes no error.
- **Stall.** While locked, hold C for 300 cycles → timing_err=1 at the counter threshold of 105, locked=0. Drive all lines high (off) afterwards → state IDLE, color=000.
- **Reset mid-operation.** Assert rst mid-dwell while locked with both errors set → all outputs 0 asynchronously. Release rst and restart the cycle → behaviour identical to the clean-cycle test.

Source files
------------

// File: rtl/rgb_cycle_decoder.sv
// Receive-side checker for the six-hue LED colour cycle: synchronises and debounces
// three active-low lines, decodes the colour, and flags sequence and dwell-time violations.
module rgb_cycle_decoder #(
    parameter int unsigned STEP_CYCLES     = 2000000,
    parameter int unsigned TOL_CYCLES      = 1000,
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned DW              = $clog2(STEP_CYCLES + TOL_CYCLES + 2)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rgb_r_n,
    input  logic          rgb_g_n,
    input  logic          rgb_b_n,
    output logic [2:0]    color,
    output logic          step_pulse,
    output logic [DW-1:0] dwell,
    output logic          locked,
    output logic          seq_err,
    output logic          timing_err
);

    localparam int unsigned SW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [SW-1:0] STAB_TOP  = SW'(DEBOUNCE_CYCLES - 1);
    localparam logic [DW-1:0] DWELL_MIN = DW'(STEP_CYCLES - TOL_CYCLES);
    localparam logic [DW-1:0] DWELL_MAX = DW'(STEP_CYCLES + TOL_CYCLES);
    localparam logic [DW-1:0] STALL_AT  = DW'(STEP_CYCLES + TOL_CYCLES + 1);
    localparam logic [DW-1:0] CNT_MAX   = '1;

    typedef enum logic [1:0] {IDLE, SYNC, LOCKED} state_t;

    state_t        state, state_next;
    logic [1:0]    sync_r, sync_g, sync_b;
    logic [2:0]    raw, cand;
    logic [SW-1:0] stab, stab_next;
    logic [DW-1:0] cnt, cnt_inc;
    logic          accept, is_next, seq_set, tim_set;

    function automatic logic is_hue(input logic [2:0] c);
        return (c != 3'b000) && (c != 3'b111);
    endfunction

    function automatic logic [2:0] succ(input logic [2:0] c);
        case (c)
            3'b100:  return 3'b110;
            3'b110:  return 3'b010;
            3'b010:  return 3'b011;
            3'b011:  return 3'b001;
            3'b001:  return 3'b101;
            3'b101:  return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    assign raw = ~{sync_r[1], sync_g[1], sync_b[1]};

    // Debounce: accept on the edge where the run of identical raw samples reaches its target.
    always_comb begin
        stab_next = '0;
        if (raw == cand) begin
            stab_next = (stab == STAB_TOP) ? stab : stab + SW'(1);
        end
    end

    assign accept  = (stab_next == STAB_TOP) && (raw != color);
    assign is_next = is_hue(color) && (raw == succ(color));
    assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + DW'(1);

    // Next state and error set conditions; an accepted change outranks the stall check.
    always_comb begin
        state_next = state;
        seq_set    = 1'b0;
        tim_set    = 1'b0;
        case (state)
            IDLE: begin
                if (accept && is_hue(raw)) state_next = SYNC;
            end
            SYNC: begin
                if (accept) begin
                    if (is_next) begin
                        state_next = LOCKED;
                    end else begin
                        seq_set    = 1'b1;
                        state_next = is_hue(raw) ? SYNC : IDLE;
                    end
                end
            end
            LOCKED: begin
                if (accept) begin
                    if (is_next) begin
                        if ((cnt_inc < DWELL_MIN) || (cnt_inc > DWELL_MAX)) tim_set = 1'b1;
                    end else begin
                        seq_set    = 1'b1;
                        state_next = is_hue(raw) ? SYNC : IDLE;
                    end
                end else if (cnt == STALL_AT) begin
                    tim_set    = 1'b1;
                    state_next = SYNC;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            sync_r     <= 2'b11;
            sync_g     <= 2'b11;
            sync_b     <= 2'b11;
            cand       <= 3'b000;
            stab       <= '0;
            cnt        <= '0;
            color      <= 3'b000;
            step_pulse <= 1'b0;
            dwell      <= '0;
            locked     <= 1'b0;
            seq_err    <= 1'b0;
            timing_err <= 1'b0;
        end else begin
            state      <= state_next;
            sync_r     <= {sync_r[0], rgb_r_n};
            sync_g     <= {sync_g[0], rgb_g_n};
            sync_b     <= {sync_b[0], rgb_b_n};
            cand       <= raw;
            stab       <= stab_next;
            step_pulse <= accept;
            locked     <= (state == LOCKED);
            if (seq_set) seq_err <= 1'b1;
            if (tim_set) timing_err <= 1'b1;
            if (accept) begin
                color <= raw;
                dwell <= cnt_inc;
                cnt   <= '0;
            end else begin
                cnt   <= cnt_inc;
            end
        end
    end

endmodule

// File: tb/tb_rgb_cycle_decoder.sv
// Bench for rgb_cycle_decoder: directed vector table, hand sequences for latency and reset,
// and random segments checked each cycle against an event-level model of the colour wheel.
module tb_rgb_cycle_decoder;

    localparam int STEP  = 100;
    localparam int TOL   = 4;
    localparam int DEB   = 4;
    localparam int DW    = 7;
    localparam int SATV  = 127;
    // Edges after an accepted change at which an unbroken hold is flagged as a stall.
    localparam int STALL = STEP + TOL + 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rgb_r_n = 1'b1, rgb_g_n = 1'b1, rgb_b_n = 1'b1;
    logic [2:0]    color;
    logic          step_pulse;
    logic [DW-1:0] dwell;
    logic          locked, seq_err, timing_err;

    rgb_cycle_decoder #(
        .STEP_CYCLES(STEP), .TOL_CYCLES(TOL), .DEBOUNCE_CYCLES(DEB), .DW(DW)
    ) dut (
        .clk(clk), .rst(rst),
        .rgb_r_n(rgb_r_n), .rgb_g_n(rgb_g_n), .rgb_b_n(rgb_b_n),
        .color(color), .step_pulse(step_pulse), .dwell(dwell),
        .locked(locked), .seq_err(seq_err), .timing_err(timing_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int at; logic [2:0] color; } ev_t;
    typedef struct {
        logic [2:0] v; int n; logic [2:0] color; logic seq; logic tim; logic lck; int dwell;
    } vec_t;

    logic [2:0] hue [6] = '{3'b100, 3'b110, 3'b010, 3'b011, 3'b001, 3'b101};

    ev_t        exp_q[$];
    vec_t       tbl[23];
    int         checks = 0, errors = 0;
    logic [2:0] drv_color = 3'b000, last_v = 3'b000;
    int         m_state = 0;  // 0 idle, 1 sync, 2 locked
    logic [2:0] m_color = 3'b000;
    int         m_dwell = 0, m_last = 0, dut_pulses = 0;
    logic       m_seq = 1'b0, m_tim = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int hue_idx(input logic [2:0] c);
        for (int i = 0; i < 6; i++) if (hue[i] == c) return i;
        return -1;
    endfunction

    function automatic logic is_succ(input logic [2:0] o, input logic [2:0] n);
        int hi = hue_idx(o);
        return (hi >= 0) && (n == hue[(hi + 1) % 6]);
    endfunction

    // Reference model: advances on bench-predicted acceptance events and compares every cycle.
    task automatic mon();
        int   d;
        logic exp_step, exp_lck;
        ev_t  ev;
        if (rst) begin
            m_state = 0; m_color = 3'b000; m_dwell = 0; m_seq = 1'b0; m_tim = 1'b0; m_last = cyc;
            chk("rst_color", int'(color), 0);
            chk("rst_step", int'(step_pulse), 0);
            chk("rst_dwell", int'(dwell), 0);
            chk("rst_locked", int'(locked), 0);
            chk("rst_seq_err", int'(seq_err), 0);
            chk("rst_timing_err", int'(timing_err), 0);
        end else begin
            exp_lck  = (m_state == 2);
            exp_step = 1'b0;
            if (exp_q.size() > 0 && exp_q[0].at == cyc) begin
                ev = exp_q.pop_front();
                exp_step = 1'b1;
                d = cyc - m_last;
                if (d > SATV) d = SATV;
                case (m_state)
                    0: if (hue_idx(ev.color) >= 0) m_state = 1;
                    1: begin
                        if (is_succ(m_color, ev.color)) m_state = 2;
                        else begin m_seq = 1'b1; m_state = (hue_idx(ev.color) >= 0) ? 1 : 0; end
                    end
                    default: begin
                        if (is_succ(m_color, ev.color)) begin
                            if (d < STEP - TOL || d > STEP + TOL) m_tim = 1'b1;
                        end else begin
                            m_seq = 1'b1; m_state = (hue_idx(ev.color) >= 0) ? 1 : 0;
                        end
                    end
                endcase
                m_color = ev.color; m_dwell = d; m_last = cyc;
            end else if (m_state == 2 && cyc - m_last == STALL) begin
                m_tim = 1'b1; m_state = 1;
            end
            if (step_pulse) dut_pulses++;
            chk($sformatf("mon_step@%0d", cyc), int'(step_pulse), int'(exp_step));
            chk($sformatf("mon_color@%0d", cyc), int'(color), int'(m_color));
            chk($sformatf("mon_dwell@%0d", cyc), int'(dwell), m_dwell);
            chk($sformatf("mon_seq_err@%0d", cyc), int'(seq_err), int'(m_seq));
            chk($sformatf("mon_timing_err@%0d", cyc), int'(timing_err), int'(m_tim));
            chk($sformatf("mon_locked@%0d", cyc), int'(locked), int'(exp_lck));
        end
    endtask

    task automatic tick();
        @(negedge clk);
        mon();
    endtask

    // Called on a falling edge; segments of DEB or more cycles with a new value get accepted.
    task automatic drive(input logic [2:0] v, input int n);
        {rgb_r_n, rgb_g_n, rgb_b_n} = ~v;
        if (n >= DEB && v != drv_color) begin
            exp_q.push_back('{at: cyc + 2 + DEB, color: v});
            drv_color = v;
        end
        last_v = v;
    endtask

    task automatic hold(input logic [2:0] v, input int n);
        drive(v, n);
        repeat (n) tick();
    endtask

    task automatic hold_watch(input logic [2:0] v, input logic [2:0] prev);
        drive(v, STEP);
        for (int j = 1; j <= STEP; j++) begin
            tick();
            if (j == DEB + 1) begin
                chk("latency_color_before", int'(color), int'(prev));
                chk("latency_step_before", int'(step_pulse), 0);
            end
            if (j == DEB + 2) begin
                chk("latency_color_at", int'(color), int'(v));
                chk("latency_step_at", int'(step_pulse), 1);
            end
        end
    endtask

    task automatic do_reset();
        tick();
        #1;
        rst = 1'b1;
        {rgb_r_n, rgb_g_n, rgb_b_n} = 3'b111;
        exp_q.delete();
        drv_color = 3'b000;
        last_v = 3'b000;
        #1;
        chk("async_color", int'(color), 0);
        chk("async_step", int'(step_pulse), 0);
        chk("async_dwell", int'(dwell), 0);
        chk("async_locked", int'(locked), 0);
        chk("async_seq_err", int'(seq_err), 0);
        chk("async_timing_err", int'(timing_err), 0);
        repeat (3) tick();
        #1 rst = 1'b0;
        tick();
    endtask

    task automatic clean_cycle();
        dut_pulses = 0;
        for (int i = 0; i < 18; i++) begin
            if (i == 2) hold_watch(hue[2], hue[1]);
            else hold(hue[i % 6], STEP);
            chk($sformatf("clean_locked_%0d", i), int'(locked), (i >= 1) ? 1 : 0);
        end
        chk("clean_pulses", dut_pulses, 18);
        chk("clean_seq_err", int'(seq_err), 0);
        chk("clean_timing_err", int'(timing_err), 0);
        chk("clean_dwell", int'(dwell), STEP);
        chk("clean_color", int'(color), 3'b101);
    endtask

    initial begin
        int         r, hi, n;
        logic [2:0] nv;

        tbl[0]  = '{3'b100, 100, 3'b100, 1'b0, 1'b0, 1'b0,  -1};
        tbl[1]  = '{3'b110, 100, 3'b110, 1'b0, 1'b0, 1'b1, 100};
        tbl[2]  = '{3'b010, 100, 3'b010, 1'b0, 1'b0, 1'b1, 100};
        tbl[3]  = '{3'b011, 100, 3'b011, 1'b0, 1'b0, 1'b1, 100};
        tbl[4]  = '{3'b001, 100, 3'b001, 1'b0, 1'b0, 1'b1, 100};
        tbl[5]  = '{3'b101, 100, 3'b101, 1'b0, 1'b0, 1'b1, 100};
        tbl[6]  = '{3'b100,  50, 3'b100, 1'b0, 1'b0, 1'b1, 100};
        tbl[7]  = '{3'b110,   3, 3'b100, 1'b0, 1'b0, 1'b1, 100};
        tbl[8]  = '{3'b100,  47, 3'b100, 1'b0, 1'b0, 1'b1, 100};
        tbl[9]  = '{3'b110, 100, 3'b110, 1'b0, 1'b0, 1'b1, 100};
        tbl[10] = '{3'b010, 100, 3'b010, 1'b0, 1'b0, 1'b1, 100};
        tbl[11] = '{3'b101, 100, 3'b101, 1'b1, 1'b0, 1'b0, 100};
        tbl[12] = '{3'b100, 100, 3'b100, 1'b1, 1'b0, 1'b1, 100};
        tbl[13] = '{3'b110, 100, 3'b110, 1'b1, 1'b0, 1'b1, 100};
        tbl[14] = '{3'b010, 104, 3'b010, 1'b1, 1'b0, 1'b1, 100};
        tbl[15] = '{3'b011,  96, 3'b011, 1'b1, 1'b0, 1'b1, 104};
        tbl[16] = '{3'b001,  95, 3'b001, 1'b1, 1'b0, 1'b1,  96};
        tbl[17] = '{3'b101, 100, 3'b101, 1'b1, 1'b1, 1'b1,  95};
        tbl[18] = '{3'b100, 100, 3'b100, 1'b1, 1'b1, 1'b1, 100};
        tbl[19] = '{3'b110, 100, 3'b110, 1'b1, 1'b1, 1'b1, 100};
        tbl[20] = '{3'b010, 100, 3'b010, 1'b1, 1'b1, 1'b1, 100};
        tbl[21] = '{3'b011, 300, 3'b011, 1'b1, 1'b1, 1'b0, 100};
        tbl[22] = '{3'b000,  20, 3'b000, 1'b1, 1'b1, 1'b0, SATV};

        do_reset();
        clean_cycle();

        do_reset();
        for (int i = 0; i < 23; i++) begin
            hold(tbl[i].v, tbl[i].n);
            chk($sformatf("vec%0d_color", i), int'(color), int'(tbl[i].color));
            chk($sformatf("vec%0d_seq_err", i), int'(seq_err), int'(tbl[i].seq));
            chk($sformatf("vec%0d_timing_err", i), int'(timing_err), int'(tbl[i].tim));
            chk($sformatf("vec%0d_locked", i), int'(locked), int'(tbl[i].lck));
            if (tbl[i].dwell >= 0) chk($sformatf("vec%0d_dwell", i), int'(dwell), tbl[i].dwell);
        end

        // Locked with both errors raised, then reset mid-dwell and replay the clean cycle.
        hold(3'b100, STEP);
        hold(3'b110, STEP);
        hold(3'b010, 50);
        chk("pre_rst_locked", int'(locked), 1);
        chk("pre_rst_seq_err", int'(seq_err), 1);
        chk("pre_rst_timing_err", int'(timing_err), 1);
        do_reset();
        clean_cycle();

        do_reset();
        for (int s = 0; s < 70; s++) begin
            r  = int'($urandom_range(0, 9));
            hi = hue_idx(drv_color);
            if (r < 6) begin
                nv = (hi >= 0) ? hue[(hi + 1) % 6] : hue[$urandom_range(0, 5)];
                n  = int'($urandom_range(STEP - 6, STEP + 6));
            end else if (r < 8) begin
                nv = 3'($urandom_range(0, 7));
                n  = int'($urandom_range(1, DEB - 1));
            end else begin
                nv = 3'($urandom_range(0, 7));
                n  = int'($urandom_range(DEB, 130));
            end
            if (nv != last_v) hold(nv, n);
        end
        repeat (150) tick();
        chk("queue_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
